// File: rtl/pseudo_spi_xfer_if.sv
// Bus bundle for the pseudo-SPI transfer engine: control, SRAM port and scan-chain pins.
// The slave modport is the engine side; the master modport is the controller/SRAM/chain side.
interface pseudo_spi_xfer_if #(
   parameter int unsigned DW   = 8,
   parameter int unsigned AW   = 10,
   parameter int unsigned LW   = 8,
   parameter int unsigned DIVW = 4
);
   logic            START;
   logic            MODE;
   logic            MSB_FIRST;
   logic [AW-1:0]   ADDR_BGN;
   logic [LW-1:0]   DATA_LEN;
   logic [DIVW-1:0] FREQ_DIV;
   logic [DW-1:0]   PI;
   logic            SPI_SI;
   logic            SCLK1;
   logic            SCLK2;
   logic            LAT;
   logic            SEL;
   logic            SPI_SO;
   logic [AW-1:0]   A;
   logic            CEN;
   logic            D_WE;
   logic [DW-1:0]   PO;
   logic            BUSY;
   logic            DONE;

   modport slave (
      input  START, MODE, MSB_FIRST, ADDR_BGN, DATA_LEN, FREQ_DIV, PI, SPI_SI,
      output SCLK1, SCLK2, LAT, SEL, SPI_SO, A, CEN, D_WE, PO, BUSY, DONE
   );

   modport master (
      output START, MODE, MSB_FIRST, ADDR_BGN, DATA_LEN, FREQ_DIV, PI, SPI_SI,
      input  SCLK1, SCLK2, LAT, SEL, SPI_SO, A, CEN, D_WE, PO, BUSY, DONE
   );
endinterface

// File: rtl/pseudo_spi_xfer.sv
// Pseudo-SPI engine moving DATA_LEN words between SRAM and an analog scan chain
// using two-phase non-overlapping clocks; every output is a registered copy of next state.
module pseudo_spi_xfer #(
   parameter int unsigned MEMORY_DATA_WIDTH = 8,
   parameter int unsigned MEMORY_ADDR_WIDTH = 10,
   parameter int unsigned RESERVED_DATA_LEN = 8,
   parameter int unsigned FREQ_DIV_WIDTH    = 4
) (
   input logic              CLK,
   input logic              BGN,
   pseudo_spi_xfer_if.slave bus
);
   localparam int unsigned DW   = MEMORY_DATA_WIDTH;
   localparam int unsigned AW   = MEMORY_ADDR_WIDTH;
   localparam int unsigned LW   = RESERVED_DATA_LEN;
   localparam int unsigned DIVW = FREQ_DIV_WIDTH;
   localparam int unsigned BW   = (DW > 1) ? $clog2(DW) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_SELP, S_RD_REQ, S_RD_CAP, S_SHIFT, S_WR, S_LATP, S_DONE
   } state_t;

   state_t          state, state_nx;
   logic            mode, mode_nx, msb, msb_nx;
   logic [DIVW-1:0] div, div_nx, pcnt, pcnt_nx;
   logic [1:0]      phase, phase_nx;
   logic [BW-1:0]   bcnt, bcnt_nx;
   logic [LW-1:0]   wcnt, wcnt_nx;
   logic [AW-1:0]   addr, addr_nx;
   logic [DW-1:0]   sreg, sreg_nx, po, po_nx;
   logic            sclk1, sclk1_nx, sclk2, sclk2_nx, lat, lat_nx, sel, sel_nx;
   logic            so, so_nx, cen, cen_nx, d_we, d_we_nx, busy, busy_nx, done, done_nx;
   logic            last_cyc;

   always_ff @(posedge CLK or negedge BGN) begin
      if (!BGN) begin
         state <= S_IDLE;
         mode  <= 1'b0;
         msb   <= 1'b0;
         div   <= '0;
         pcnt  <= '0;
         phase <= '0;
         bcnt  <= '0;
         wcnt  <= '0;
         addr  <= '0;
         sreg  <= '0;
         po    <= '0;
         sclk1 <= 1'b0;
         sclk2 <= 1'b0;
         lat   <= 1'b0;
         sel   <= 1'b0;
         so    <= 1'b0;
         cen   <= 1'b1;
         d_we  <= 1'b1;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nx;
         mode  <= mode_nx;
         msb   <= msb_nx;
         div   <= div_nx;
         pcnt  <= pcnt_nx;
         phase <= phase_nx;
         bcnt  <= bcnt_nx;
         wcnt  <= wcnt_nx;
         addr  <= addr_nx;
         sreg  <= sreg_nx;
         po    <= po_nx;
         sclk1 <= sclk1_nx;
         sclk2 <= sclk2_nx;
         lat   <= lat_nx;
         sel   <= sel_nx;
         so    <= so_nx;
         cen   <= cen_nx;
         d_we  <= d_we_nx;
         busy  <= busy_nx;
         done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      mode_nx  = mode;
      msb_nx   = msb;
      div_nx   = div;
      pcnt_nx  = pcnt;
      phase_nx = phase;
      bcnt_nx  = bcnt;
      wcnt_nx  = wcnt;
      addr_nx  = addr;
      sreg_nx  = sreg;
      last_cyc = (pcnt == div);

      case (state)
         S_IDLE, S_DONE: begin
            if (bus.START) begin
               mode_nx  = bus.MODE;
               msb_nx   = bus.MSB_FIRST;
               div_nx   = bus.FREQ_DIV;
               addr_nx  = bus.ADDR_BGN;
               wcnt_nx  = bus.DATA_LEN;
               pcnt_nx  = '0;
               phase_nx = '0;
               bcnt_nx  = '0;
               // An empty transfer borrows RD_CAP as its single busy cycle.
               if (bus.DATA_LEN == '0) state_nx = S_RD_CAP;
               else if (bus.MODE)      state_nx = S_SELP;
               else                    state_nx = S_RD_REQ;
            end
         end
         S_SELP: begin
            if (last_cyc) begin
               pcnt_nx  = '0;
               state_nx = S_SHIFT;
            end else begin
               pcnt_nx = pcnt + 1'b1;
            end
         end
         S_RD_REQ: state_nx = S_RD_CAP;
         S_RD_CAP: begin
            if (wcnt == '0) begin
               state_nx = S_DONE;
            end else begin
               sreg_nx  = bus.PI;
               state_nx = S_SHIFT;
            end
         end
         S_SHIFT: begin
            if (mode && phase == 2'd1 && last_cyc)
               sreg_nx = msb ? {sreg[DW-2:0], bus.SPI_SI} : {bus.SPI_SI, sreg[DW-1:1]};
            if (!last_cyc) begin
               pcnt_nx = pcnt + 1'b1;
            end else begin
               pcnt_nx  = '0;
               phase_nx = phase + 2'd1;
               if (phase == 2'd3) begin
                  if (!mode)
                     sreg_nx = msb ? {sreg[DW-2:0], 1'b0} : {1'b0, sreg[DW-1:1]};
                  if (bcnt == BW'(DW - 1)) begin
                     bcnt_nx = '0;
                     if (mode) begin
                        state_nx = S_WR;
                     end else begin
                        wcnt_nx = wcnt - 1'b1;
                        if (wcnt == LW'(1)) begin
                           state_nx = S_LATP;
                        end else begin
                           addr_nx  = addr + 1'b1;
                           state_nx = S_RD_REQ;
                        end
                     end
                  end else begin
                     bcnt_nx = bcnt + 1'b1;
                  end
               end
            end
         end
         S_WR: begin
            wcnt_nx  = wcnt - 1'b1;
            addr_nx  = addr + 1'b1;
            state_nx = (wcnt == LW'(1)) ? S_DONE : S_SHIFT;
         end
         S_LATP: begin
            if (last_cyc) begin
               pcnt_nx  = '0;
               state_nx = S_DONE;
            end else begin
               pcnt_nx = pcnt + 1'b1;
            end
         end
         default: state_nx = S_IDLE;
      endcase

      // Outputs follow the next state so they line up with it once registered.
      sclk1_nx = (state_nx == S_SHIFT) && (phase_nx == 2'd1);
      sclk2_nx = (state_nx == S_SHIFT) && (phase_nx == 2'd3);
      lat_nx   = (state_nx == S_LATP);
      sel_nx   = (state_nx == S_SELP);
      so_nx    = (state_nx == S_SHIFT) && !mode_nx && (msb_nx ? sreg_nx[DW-1] : sreg_nx[0]);
      cen_nx   = !((state_nx == S_RD_REQ) || (state_nx == S_WR));
      d_we_nx  = (state_nx != S_WR);
      po_nx    = (state_nx == S_WR) ? sreg_nx : po;
      busy_nx  = (state_nx != S_IDLE) && (state_nx != S_DONE);
      done_nx  = (state_nx == S_DONE);
   end

   assign bus.SCLK1  = sclk1;
   assign bus.SCLK2  = sclk2;
   assign bus.LAT    = lat;
   assign bus.SEL    = sel;
   assign bus.SPI_SO = so;
   assign bus.A      = addr;
   assign bus.CEN    = cen;
   assign bus.D_WE   = d_we;
   assign bus.PO     = po;
   assign bus.BUSY   = busy;
   assign bus.DONE   = done;
endmodule
